// File: rtl/encoder_4to2_dut.sv
// encoder_4to2_dut
//   Registered 4-to-2 encoder for one-hot request vectors. The index is built
//   from plain OR equations, so a multi-hot input yields the bitwise OR of the
//   indices of all set lines rather than a prioritized pick. Two side flags
//   travel with the index: valid (any line set) and err (two or more lines set).
//   Everything is registered: one cycle of latency, sampled every cycle.
//
// Ports
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset, clears all outputs
//   i      in   4  request vector, i[0] is the lowest-index line
//   y      out  2  registered encoded index
//   valid  out  1  registered: at least one line was set
//   err    out  1  registered: more than one line was set
module encoder_4to2_dut (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i,
    output logic [1:0] y,
    output logic       valid,
    output logic       err
);

    typedef struct packed {
        logic [1:0] y;
        logic       valid;
        logic       err;
    } enc_rsp_t;

    enc_rsp_t rsp_d;
    enc_rsp_t rsp_q;

    always_comb begin
        rsp_d       = '0;
        // Each output bit is set by the lines whose index has that bit set.
        rsp_d.y[0]  = i[1] | i[3];
        rsp_d.y[1]  = i[2] | i[3];
        rsp_d.valid = |i;
        // Two or more lines set <=> some pair of lines is set together.
        rsp_d.err   = (i[0] & i[1]) | (i[0] & i[2]) | (i[0] & i[3]) |
                      (i[1] & i[2]) | (i[1] & i[3]) | (i[2] & i[3]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    assign y     = rsp_q.y;
    assign valid = rsp_q.valid;
    assign err   = rsp_q.err;

endmodule

// File: tb/tb_encoder_4to2_dut.sv
module tb_encoder_4to2_dut;

    logic       clk;
    logic       rst_n;
    logic [3:0] i;
    logic [1:0] y;
    logic       valid;
    logic       err;

    int total = 0;
    int bad   = 0;

    encoder_4to2_dut dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i     (i),
        .y     (y),
        .valid (valid),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] i;
        logic [1:0] y;
        logic       v;
        logic       e;
    } vec_t;

    vec_t tbl[9];

    // Reference: index of a one-hot line; multi-hot ORs the indices of all set
    // lines together. Flags come from the population count.
    task automatic model(input logic [3:0] v, output logic [1:0] ey,
                         output logic ev, output logic ee);
        int cnt;
        int idx;
        cnt = 0;
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            if (v[k]) begin
                cnt++;
                idx = idx | k;
            end
        end
        ey = idx[1:0];
        ev = (cnt >= 1);
        ee = (cnt >= 2);
    endtask

    task automatic check(input string name, input logic [1:0] ey,
                         input logic ev, input logic ee);
        total++;
        if (y !== ey) begin
            bad++;
            $display("FAIL %s y: got %b want %b", name, y, ey);
        end
        total++;
        if (valid !== ev) begin
            bad++;
            $display("FAIL %s valid: got %b want %b", name, valid, ev);
        end
        total++;
        if (err !== ee) begin
            bad++;
            $display("FAIL %s err: got %b want %b", name, err, ee);
        end
    endtask

    // Called just after a rising edge: set input, let it be captured, then check.
    task automatic apply(input logic [3:0] v);
        i = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] ey;
        logic       ev;
        logic       ee;
        logic [3:0] r;

        tbl[0] = '{4'b0001, 2'b00, 1'b1, 1'b0};
        tbl[1] = '{4'b0010, 2'b01, 1'b1, 1'b0};
        tbl[2] = '{4'b0100, 2'b10, 1'b1, 1'b0};
        tbl[3] = '{4'b1000, 2'b11, 1'b1, 1'b0};
        tbl[4] = '{4'b0000, 2'b00, 1'b0, 1'b0};
        tbl[5] = '{4'b0101, 2'b10, 1'b1, 1'b1};
        tbl[6] = '{4'b0011, 2'b01, 1'b1, 1'b1};
        tbl[7] = '{4'b1001, 2'b11, 1'b1, 1'b1};
        tbl[8] = '{4'b1111, 2'b11, 1'b1, 1'b1};

        // Reset held with a live input: outputs stay clear across edges.
        rst_n = 1'b0;
        i     = 4'b1000;
        #1;
        check("reset_imm", 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("reset_hold", 2'b00, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 2'b11, 1'b1, 1'b0);

        // Table: walking one, zero, multi-hot on consecutive cycles.
        foreach (tbl[k]) begin
            apply(tbl[k].i);
            check($sformatf("tbl_%b", tbl[k].i), tbl[k].y, tbl[k].v, tbl[k].e);
        end

        // Random sweep against the reference model.
        for (int k = 0; k < 24; k++) begin
            r = 4'($urandom_range(0, 15));
            apply(r);
            model(r, ey, ev, ee);
            check($sformatf("rand_%0d_%b", k, r), ey, ev, ee);
        end

        // Output holds until the next edge: a change mid-cycle is not visible.
        apply(4'b0100);
        i = 4'b0001;
        #2;
        check("hold_mid_cycle", 2'b10, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("hold_next_edge", 2'b00, 1'b1, 1'b0);

        // Asynchronous reset mid-operation, between edges, while y=11.
        apply(4'b1000);
        check("pre_async", 2'b11, 1'b1, 1'b0);
        i = 4'b0110;            // pending value that reset must discard
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", 2'b00, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        i     = 4'b1000;
        @(posedge clk);
        #1;
        check("async_resume", 2'b11, 1'b1, 1'b0);
        apply(4'b0010);
        check("async_resume2", 2'b01, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
